seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_decode.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the 4-digit segment scan controller
// Contents: digit count, active-low segment patterns (bit 6 = a .. bit 0 = g),
//           dash/blank patterns, and the 2-bit digit index type.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational BCD nibble to active-low 7-segment decoder
// Ports:
//   i_nibble  in   4  BCD digit; values A-F render as a dash
//   o_seg     out  7  active-low cathodes, bit 6 = segment a, bit 0 = segment g
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 4-digit 7-segment scan controller with tear-free value load
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   asynchronous active-low reset
//   value_i      in   16  four BCD nibbles, [3:0] is digit 0 (rightmost)
//   value_valid  in   1   value_i offered
//   value_ready  out  1   one-entry pending register is empty
//   blank_mask   in   4   bit d forces digit d dark (live)
//   lzb_en       in   1   leading-zero blanking enable (live)
//   bright       in   3   brightness 0..7, 7 = whole slot (live)
//   an           out  4   active-low anodes, registered
//   seg          out  7   active-low cathodes, registered
//   frame_tick   out  1   high during the cycle the digit index wraps 3->0
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 262144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [3:0]  blank_mask,
  input  logic        lzb_en,
  input  logic [2:0]  bright,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int PW = $clog2(DIGIT_TICKS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIGIT_TICKS - 1);
  localparam logic [PW-1:0] PRESC_PRE = PW'(DIGIT_TICKS - 2);

  logic [PW-1:0] r_presc;
  digit_idx_t    r_digit;
  logic [15:0]   r_pend;
  logic          r_pend_full;
  logic [15:0]   r_disp;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame_tick;

  logic          w_slot_end;
  logic          w_frame_start;
  logic          w_accept;
  logic [3:0]    w_nib;
  logic [6:0]    w_dec_seg;
  logic          w_lead_zero;
  logic          w_dim_on;
  logic          w_guard;
  logic          w_blank;

  assign w_slot_end    = (r_presc == PRESC_MAX);
  assign w_frame_start = w_slot_end && (r_digit == digit_idx_t'(NUM_DIGITS - 1));
  assign w_accept      = value_valid && !r_pend_full;
  assign value_ready   = !r_pend_full;

  assign w_nib = r_disp[{r_digit, 2'b00} +: 4];

  // Digit d is a leading zero when it and every higher nibble are zero;
  // digit 0 always shows so a zero value still reads "0".
  assign w_lead_zero = lzb_en && (r_digit != 2'd0) && ((r_disp >> {r_digit, 2'b00}) == 16'h0000);

  // Slot is split into eighths by the top three prescaler bits; the anode
  // stays on for the first bright+1 eighths.
  assign w_dim_on = (r_presc[PW-1 -: 3] <= bright);

  // First tick of every slot is dark so the previous digit's cathodes never
  // bleed into the newly selected anode.
  assign w_guard = (r_presc == '0);

  assign w_blank = blank_mask[r_digit] || w_lead_zero || !w_dim_on || w_guard;

  seg_decode u_decode (
    .i_nibble (w_nib),
    .o_seg    (w_dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_digit      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + PW'(1);
      if (w_slot_end) begin
        r_digit <= r_digit + 2'd1;
      end
      // Registered one cycle early so the pulse lines up with the wrap cycle.
      r_frame_tick <= (r_presc == PRESC_PRE) && (r_digit == digit_idx_t'(NUM_DIGITS - 1));
    end
  end

  // Display register only moves at frame start, so a frame never mixes
  // digits from two different values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_disp      <= '0;
    end else begin
      if (w_frame_start && r_pend_full) begin
        r_disp      <= r_pend;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend      <= value_i;
        r_pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
    end else if (w_blank) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= w_dec_seg;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl with DIGIT_TICKS=16
module tb_seg_scan_ctrl;

  localparam int DT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_i;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  blank_mask;
  logic        lzb_en;
  logic [2:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGIT_TICKS(DT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_i     (value_i),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_mask  (blank_mask),
    .lzb_en      (lzb_en),
    .bright      (bright),
    .an          (an),
    .seg         (seg),
    .frame_tick  (frame_tick)
  );

  // One expected frame: pattern per digit, lit cycles per lit digit, which digits light.
  typedef struct {
    string            name;
    logic [3:0][6:0]  segs;
    int               cnt;
    logic [3:0]       lit;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_busy = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0000100, PD = 7'b1111110;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input string name, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input int cnt, input logic [3:0] lit);
    exp_t e;
    e.name = name;
    e.segs[3] = s3; e.segs[2] = s2; e.segs[1] = s1; e.segs[0] = s0;
    e.cnt = cnt;
    e.lit = lit;
    return e;
  endfunction

  // Monitor: for each expected entry, wait for a frame_tick, skip one cycle, then
  // observe exactly one frame (64 cycles) of registered an/seg output.
  initial begin : monitor
    exp_t e;
    int n, z, dd, formbad, ticks, tick_i;
    int cnt[4];
    int first[4];
    int segbad[4];
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) continue;
      mon_busy = 1'b1;
      e = exp_q.pop_front();
      n = 0;
      while (!frame_tick && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!frame_tick) begin
        chk({e.name, "/tick_timeout"}, 0, 1);
      end else begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          cnt[k] = 0; first[k] = -1; segbad[k] = 0;
        end
        formbad = 0; ticks = 0; tick_i = -1;
        for (int i = 0; i < 64; i++) begin
          @(negedge clk);
          z = 0; dd = 0;
          for (int k = 0; k < 4; k++) begin
            if (!an[k]) begin z++; dd = k; end
          end
          if (z > 1) formbad++;
          else if (z == 1) begin
            cnt[dd]++;
            if (first[dd] == -1) first[dd] = i;
            if (seg !== e.segs[dd]) segbad[dd]++;
          end else if (seg !== 7'h7F) formbad++;
          if (frame_tick) begin ticks++; tick_i = i; end
        end
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("%s/cnt_d%0d", e.name, k), cnt[k], e.lit[k] ? e.cnt : 0);
          chk($sformatf("%s/first_d%0d", e.name, k), first[k], e.lit[k] ? 16 * k + 1 : -1);
          chk($sformatf("%s/seg_d%0d", e.name, k), segbad[k], 0);
        end
        chk({e.name, "/an_form"}, formbad, 0);
        chk({e.name, "/tick_pos"}, ticks * 100 + tick_i, 162);
      end
      mon_busy = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_tick(input int extra);
    int n = 0;
    while (!frame_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!frame_tick) chk("wait_tick_timeout", 0, 1);
    repeat (extra) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v, input string nm);
    chk({nm, "/ready_before"}, value_ready, 1);
    value_i = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    chk({nm, "/ready_drop"}, value_ready, 0);
  endtask

  initial begin : stim
    int n, bad, tick_n;
    rst_n = 1'b0; value_i = '0; value_valid = 1'b0;
    blank_mask = 4'b0000; lzb_en = 1'b0; bright = 3'd7;
    repeat (3) @(negedge clk);
    chk("rst/an", an, 4'hF);
    chk("rst/seg", seg, 7'h7F);
    chk("rst/frame_tick", frame_tick, 0);
    chk("rst/value_ready", value_ready, 1);
    rst_n = 1'b1;
    exp_q.push_back(mk("idle", P0, P0, P0, P0, 15, 4'b1111));

    // Handshake and tear-free load of 0x1234.
    wait_idle();
    wait_tick(20);
    send(16'h1234, "h1234");
    exp_q.push_back(mk("h1234", P1, P2, P3, P4, 15, 4'b1111));
    n = 0; bad = 0;
    while (!frame_tick && n < 200) begin
      if (an != 4'hF && seg != P0) bad++;
      @(negedge clk);
      n++;
    end
    chk("h1234/no_tear", bad, 0);
    chk("h1234/ready_at_tick", value_ready, 0);
    @(negedge clk);
    chk("h1234/ready_after_tick", value_ready, 1);

    // Back-to-back: valid held, second value waits for the frame start.
    wait_idle();
    wait_tick(10);
    chk("b2b/ready1", value_ready, 1);
    value_i = 16'h5678; value_valid = 1'b1;
    exp_q.push_back(mk("h5678", P5, P6, P7, P8, 15, 4'b1111));
    exp_q.push_back(mk("h9999", P9, P9, P9, P9, 15, 4'b1111));
    @(negedge clk);
    value_i = 16'h9999;
    n = 0; tick_n = -100;
    while (!value_ready && n < 200) begin
      if (frame_tick) tick_n = n;
      @(negedge clk);
      n++;
    end
    chk("b2b/second_after_tick", n - tick_n, 1);
    @(negedge clk);
    value_valid = 1'b0;
    chk("b2b/ready_drop2", value_ready, 0);

    // Leading-zero blanking.
    wait_idle();
    lzb_en = 1'b1;
    wait_tick(10);
    send(16'h0070, "h0070");
    exp_q.push_back(mk("h0070_lzb", P0, P0, P7, P0, 15, 4'b0011));

    // Dash decode with dimming.
    wait_idle();
    lzb_en = 1'b0;
    bright = 3'd1;
    wait_tick(10);
    send(16'h00AF, "h00AF");
    exp_q.push_back(mk("h00AF_dim", P0, P0, PD, PD, 3, 4'b1111));

    // Reset mid-slot on digit 2 with a pending value.
    wait_idle();
    bright = 3'd7;
    wait_tick(10);
    send(16'h4321, "h4321");
    n = 0;
    while (an != 4'b1011 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst2/reached_digit2", an, 4'b1011);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2/an", an, 4'hF);
    chk("rst2/seg", seg, 7'h7F);
    chk("rst2/ready", value_ready, 1);
    chk("rst2/frame_tick", frame_tick, 0);
    repeat (2) @(negedge clk);
    blank_mask = 4'b0100;
    rst_n = 1'b1;
    exp_q.push_back(mk("post_rst_mask", P0, P0, P0, P0, 15, 4'b1011));
    n = 0;
    while (an == 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst2/restart_digit0", an, 4'b1110);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
